// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks every butterfly of an in-place radix-2 DIT FFT, emitting stage, index, addresses and twiddle
module fft_stage_sequencer #(
  parameter int LOG2_N = 6,
  localparam int STAGE_W = $clog2(LOG2_N),
  localparam int BF_W = LOG2_N - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  input  logic               abort,
  input  logic               continuous,
  output logic [STAGE_W-1:0] stage,
  output logic [BF_W-1:0]    count,
  output logic [LOG2_N-1:0]  addr_a,
  output logic [LOG2_N-1:0]  addr_b,
  output logic [BF_W-1:0]    tw_idx,
  output logic               valid,
  output logic               new_stage,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [BF_W-1:0]     count_q, count_d;
  logic [LOG2_N-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [BF_W-1:0]     tw_q, tw_d;
  logic                done_q, done_d;
  logic [LOG2_N-1:0]   cw, mask, tw_full;
  logic                last_c, last_s;
  assign last_c = &count_q;
  assign last_s = stage_q == STAGE_W'(LOG2_N - 1);
  // Next state and butterfly position; abort overrides everything including the final consume
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        stage_d = '0;
        count_d = '0;
      end
    end else if (!hold) begin
      if (!last_c) begin
        count_d = count_q + 1'b1;
      end else if (!last_s) begin
        count_d = '0;
        stage_d = stage_q + 1'b1;
      end else begin
        count_d = '0;
        stage_d = '0;
        done_d  = 1'b1;
        state_d = continuous ? RUN : IDLE;
      end
    end
    if (abort) begin
      state_d = IDLE;
      stage_d = '0;
      count_d = '0;
      done_d  = 1'b0;
    end
  end
  // Address and twiddle terms for the next tuple, forced to zero when idle
  always_comb begin
    cw       = LOG2_N'(count_d);
    mask     = (LOG2_N'(1) << stage_d) - 1'b1;
    tw_full  = (cw & mask) << (LOG2_N - 1 - int'(stage_d));
    addr_a_d = (state_d == RUN) ? (((cw & ~mask) << 1) | (cw & mask)) : '0;
    addr_b_d = (state_d == RUN) ? (addr_a_d | (LOG2_N'(1) << stage_d)) : '0;
    tw_d     = (state_d == RUN) ? tw_full[BF_W-1:0] : '0;
  end
  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      count_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      count_q  <= count_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      done_q   <= done_d;
    end
  end
  assign stage     = stage_q;
  assign count     = count_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_idx    = tw_q;
  assign done      = done_q;
  assign valid     = state_q == RUN;
  assign busy      = state_q == RUN;
  assign new_stage = (state_q == RUN) && (count_q == '0);
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed and random checks of two sequencer sizes against a frame-position model
module tb_fft_stage_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [2:0] st6;
  logic [4:0] cnt6, tw6;
  logic [5:0] aa6, ab6;
  logic v6, ns6, b6, d6;
  logic [0:0] st2, cnt2, tw2;
  logic [1:0] aa2, ab2;
  logic v2, ns2, b2, d2;
  int tests = 0, fails = 0;
  bit mrun[2];
  int mp[2];
  bit mdone[2];
  int ml[2] = '{6, 2};
  int nvalid, ndone, n;
  bit seen;
  int t_aa[4] = '{0, 2, 0, 1};
  int t_ab[4] = '{1, 3, 2, 3};
  int t_tw[4] = '{0, 0, 0, 1};
  always #5 clk = ~clk;
  fft_stage_sequencer #(.LOG2_N(6)) dut (.clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .continuous(continuous), .stage(st6), .count(cnt6), .addr_a(aa6), .addr_b(ab6), .tw_idx(tw6),
    .valid(v6), .new_stage(ns6), .busy(b6), .done(d6));
  fft_stage_sequencer #(.LOG2_N(2)) dut2 (.clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .continuous(continuous), .stage(st2), .count(cnt2), .addr_a(aa2), .addr_b(ab2), .tw_idx(tw2),
    .valid(v2), .new_stage(ns2), .busy(b2), .done(d2));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mrun[k] = 0; mp[k] = 0; mdone[k] = 0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int last;
      last = ml[k] * (1 << (ml[k] - 1)) - 1;
      if (!rst || abort) begin
        mrun[k] = 0; mp[k] = 0; mdone[k] = 0;
      end else if (!mrun[k]) begin
        mdone[k] = 0;
        if (start) begin mrun[k] = 1; mp[k] = 0; end
      end else if (hold) begin
        mdone[k] = 0;
      end else if (mp[k] == last) begin
        mdone[k] = 1; mrun[k] = continuous; mp[k] = 0;
      end else begin
        mp[k]++; mdone[k] = 0;
      end
    end
  endtask
  task automatic check_one(int k, string p, logic [31:0] st, logic [31:0] cnt, logic [31:0] aa,
                           logic [31:0] ab, logic [31:0] tw, logic v, logic ns, logic b, logic d);
    int half, s, c, ea, eb, etw;
    half = 1 << (ml[k] - 1);
    s = mrun[k] ? mp[k] / half : 0;
    c = mrun[k] ? mp[k] % half : 0;
    ea = mrun[k] ? (((c >> s) << (s + 1)) + (c % (1 << s))) : 0;
    eb = mrun[k] ? ea + (1 << s) : 0;
    etw = mrun[k] ? (c % (1 << s)) * (1 << (ml[k] - 1 - s)) : 0;
    chk({p, ".stage"}, st, s);
    chk({p, ".count"}, cnt, c);
    chk({p, ".addr_a"}, aa, ea);
    chk({p, ".addr_b"}, ab, eb);
    chk({p, ".tw_idx"}, tw, etw);
    chk({p, ".valid"}, {31'b0, v}, {31'b0, mrun[k]});
    chk({p, ".busy"}, {31'b0, b}, {31'b0, mrun[k]});
    chk({p, ".new_stage"}, {31'b0, ns}, (mrun[k] && c == 0) ? 1 : 0);
    chk({p, ".done"}, {31'b0, d}, {31'b0, mdone[k]});
  endtask
  task automatic check_all();
    check_one(0, "n64", st6, cnt6, aa6, ab6, tw6, v6, ns6, b6, d6);
    check_one(1, "n4", st2, cnt2, aa2, ab2, tw2, v2, ns2, b2, d2);
  endtask
  task automatic cyc(int k);
    repeat (k) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (v6) nvalid++;
      if (d6) ndone++;
    end
  endtask
  task automatic run_until_done(int max, output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (!d6 && cnt < max);
    chk("done_seen", {31'b0, d6}, 1);
  endtask
  initial begin
    model_reset();
    cyc(2);
    rst = 1'b1;
    cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(113);
    chk("mid.stage", st6, 3);
    chk("mid.count", cnt6, 17);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("async_rst.valid", {31'b0, v6}, 0);
    cyc(1);
    rst = 1'b1; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart.stage", st6, 0);
    chk("restart.count", cnt6, 0);
    chk("restart.new_stage", {31'b0, ns6}, 1);
    nvalid = 1; ndone = 0; seen = 0; n = 0;
    do begin
      cyc(1);
      n++;
      if (v6 && st6 == 2 && cnt6 == 5) begin
        seen = 1;
        chk("s2c5.addr_a", aa6, 9);
        chk("s2c5.addr_b", ab6, 13);
        chk("s2c5.tw_idx", tw6, 8);
      end
    end while (!d6 && n < 300);
    chk("single.valid_cycles", nvalid, 192);
    chk("single.done_count", ndone, 1);
    chk("single.done_cycle", n, 192);
    chk("single.s2c5_seen", {31'b0, seen}, 1);
    cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(159);
    hold = 1'b1; cyc(3);
    chk("hold.stage", st6, 4);
    chk("hold.count", cnt6, 31);
    hold = 1'b0; cyc(1);
    chk("after_hold.stage", st6, 5);
    chk("after_hold.count", cnt6, 0);
    run_until_done(100, n);
    chk("hold.done_delay", n, 32);
    continuous = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    nvalid = 1; ndone = 0;
    cyc(191);
    cyc(1);
    chk("cont.done", {31'b0, d6}, 1);
    chk("cont.restart_stage", st6, 0);
    chk("cont.restart_count", cnt6, 0);
    chk("cont.restart_new_stage", {31'b0, ns6}, 1);
    cyc(190);
    continuous = 1'b0;
    cyc(2);
    chk("cont.done2", {31'b0, d6}, 1);
    chk("cont.valid_end", {31'b0, v6}, 0);
    chk("cont.valid_cycles", nvalid, 384);
    chk("cont.done_count", ndone, 2);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(42);
    chk("abort.stage", st6, 1);
    chk("abort.count", cnt6, 10);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort.valid", {31'b0, v6}, 0);
    chk("abort.done", {31'b0, d6}, 0);
    start = 1'b1; cyc(1);
    cyc(191);
    chk("abort_last.stage", st6, 5);
    chk("abort_last.count", cnt6, 31);
    abort = 1'b1; continuous = 1'b1; cyc(1);
    abort = 1'b0; continuous = 1'b0; start = 1'b0;
    chk("abort_last.valid", {31'b0, v6}, 0);
    chk("abort_last.done", {31'b0, d6}, 0);
    cyc(1);
    chk("abort_last.no_done", {31'b0, d6}, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("n4tab.stage", st2, i / 2);
      chk("n4tab.count", cnt2, i % 2);
      chk("n4tab.addr_a", aa2, t_aa[i]);
      chk("n4tab.addr_b", ab2, t_ab[i]);
      chk("n4tab.tw_idx", tw2, t_tw[i]);
      cyc(1);
    end
    chk("n4tab.done", {31'b0, d2}, 1);
    chk("n4tab.valid_end", {31'b0, v2}, 0);
    repeat (3000) begin
      start = $urandom_range(0, 7) == 0;
      hold = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 199) == 0;
      continuous = $urandom_range(0, 1) == 1;
      cyc(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
